// File: rtl/serv_state_wide.sv
// serv_state_wide: beat counter, two-stage phase sequencing, bus/RF request
// generation and misalign-trap capture for a W-bit-per-beat serial core.
module serv_state_wide #(
  parameter int    W              = 1,
  parameter bit    WITH_CSR       = 1,
  parameter bit    ALIGN          = 0,
  parameter bit    MDU            = 0,
  parameter string RESET_STRATEGY = "MINI"
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_new_irq,
  input  logic       i_alu_cmp,
  input  logic       i_ctrl_misalign,
  input  logic       i_mem_misalign,
  input  logic       i_sh_done,
  input  logic       i_sh_done_r,
  input  logic       i_bne_or_bge,
  input  logic       i_cond_branch,
  input  logic       i_dbus_en,
  input  logic       i_two_stage_op,
  input  logic       i_branch_op,
  input  logic       i_shift_op,
  input  logic       i_sh_right,
  input  logic       i_slt_or_branch,
  input  logic       i_e_op,
  input  logic       i_rd_op,
  input  logic       i_mdu_op,
  input  logic       i_mdu_ready,
  input  logic       i_ibus_ack,
  input  logic       i_dbus_ack,
  input  logic       i_rf_ready,
  input  logic       i_cnt_stall,
  output logic       o_cnt_en,
  output logic [4:0] o_cnt_pos,
  output logic [3:0] o_cnt_bit,
  output logic       o_cnt7,
  output logic       o_cnt0to3,
  output logic       o_cnt12to31,
  output logic       o_cnt_done,
  output logic [1:0] o_mem_bytecnt,
  output logic       o_init,
  output logic       o_bufreg_en,
  output logic       o_ctrl_pc_en,
  output logic       o_ctrl_jump,
  output logic       o_ctrl_trap,
  output logic       o_mdu_valid,
  output logic       o_ibus_cyc,
  output logic       o_dbus_cyc,
  output logic       o_rf_rreq,
  output logic       o_rf_wreq,
  output logic       o_rf_rd_en
);

  typedef enum logic [1:0] {PH_IDLE, PH_RUN1, PH_WAIT, PH_RUN2} phase_e;

  localparam logic [4:0] STEP    = 5'(W);
  localparam logic [4:0] LAST    = 5'(32 - W);
  localparam bit         RST_ALL = (RESET_STRATEGY != "NONE");

  phase_e     phase_q, phase_d;
  logic [4:0] pos_q, pos_d;
  logic       jump_q, jump_d;
  logic       trap_q, trap_d;
  logic       ibus_q, ibus_d;
  logic       fw_q, fw_d;

  logic       running, in_wait, cnt_en, cnt_done, init, pc_en;
  logic       take_branch, trap_pending, first_wait, shift_ok;
  logic [5:0] pos_end;

  assign running      = (phase_q == PH_RUN1) || (phase_q == PH_RUN2);
  assign in_wait      = (phase_q == PH_WAIT);
  assign cnt_en       = running && !i_cnt_stall;
  assign cnt_done     = cnt_en && (pos_q == LAST);
  assign init         = i_two_stage_op && !i_new_irq && !in_wait && (phase_q != PH_RUN2);
  assign pc_en        = cnt_en && !init;
  assign take_branch  = i_branch_op && (!i_cond_branch || (i_alu_cmp ^ i_bne_or_bge));
  assign trap_pending = (take_branch && i_ctrl_misalign && !ALIGN) ||
                        (i_dbus_en && i_mem_misalign);
  assign first_wait   = in_wait && fw_q;
  assign shift_ok     = i_shift_op && (i_sh_done || !i_sh_right);
  assign pos_end      = {1'b0, pos_q} + 6'(W);

  // Phase and position registers; ibus_cyc comes out of reset requesting a fetch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_q <= PH_IDLE;
      pos_q   <= '0;
      ibus_q  <= 1'b1;
    end else begin
      phase_q <= phase_d;
      pos_q   <= pos_d;
      ibus_q  <= ibus_d;
    end
  end

  // Jump/trap capture and first-WAIT marker; reset can be stripped from these.
  always_ff @(posedge i_clk) begin
    if (i_rst && RST_ALL) begin
      jump_q <= 1'b0;
      trap_q <= 1'b0;
      fw_q   <= 1'b0;
    end else begin
      jump_q <= jump_d;
      trap_q <= trap_d;
      fw_q   <= fw_d;
    end
  end

  // Next-state: phase sequencing, beat counter, end-of-RUN1 capture, fetch request.
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      PH_IDLE: if (i_rf_ready) phase_d = PH_RUN1;
      PH_RUN1: if (cnt_done)   phase_d = init ? PH_WAIT : PH_IDLE;
      PH_WAIT: if (i_rf_ready) phase_d = PH_RUN2;
      PH_RUN2: if (cnt_done)   phase_d = PH_IDLE;
      default:                 phase_d = PH_IDLE;
    endcase
    // 5-bit add wraps to 0 after the last beat
    pos_d  = cnt_en ? pos_q + STEP : pos_q;
    jump_d = jump_q;
    trap_d = trap_q;
    if ((phase_q == PH_RUN1) && cnt_done) begin
      jump_d = take_branch;
      trap_d = WITH_CSR && trap_pending;
    end
    ibus_d = ibus_q;
    if (i_ibus_ack)             ibus_d = 1'b0;
    else if (cnt_done && pc_en) ibus_d = 1'b1;
    fw_d = (phase_q == PH_RUN1) && cnt_done && init;
  end

  // Outputs: position decodes, stage control and request strobes.
  always_comb begin
    o_cnt_en      = cnt_en;
    o_cnt_pos     = pos_q;
    o_cnt_done    = cnt_done;
    o_mem_bytecnt = pos_q[4:3];
    for (int k = 0; k < 4; k++)
      o_cnt_bit[k] = cnt_en && ({1'b0, pos_q} <= 6'(k)) && (6'(k) < pos_end);
    o_cnt7        = cnt_en && (pos_q <= 5'd7) && (pos_end > 6'd7);
    o_cnt0to3     = cnt_en && (pos_q < 5'd4);
    o_cnt12to31   = cnt_en && (pos_end > 6'd12);
    o_init        = init;
    o_ctrl_pc_en  = pc_en;
    o_ctrl_jump   = jump_q;
    o_ctrl_trap   = WITH_CSR && (i_e_op || i_new_irq || trap_q);
    o_bufreg_en   = (cnt_en && (init || ((o_ctrl_trap || i_branch_op) && i_two_stage_op))) ||
                    (in_wait && i_shift_op && !first_wait && (i_sh_right || i_sh_done_r));
    o_mdu_valid   = MDU && in_wait && i_mdu_op;
    o_ibus_cyc    = ibus_q && !i_rst;
    o_dbus_cyc    = in_wait && i_dbus_en && !i_mem_misalign;
    o_rf_wreq     = in_wait && !trap_q &&
                    (shift_ok || i_dbus_ack || (MDU && i_mdu_ready) || i_slt_or_branch);
    o_rf_rreq     = i_ibus_ack || (first_wait && trap_q);
    o_rf_rd_en    = i_rd_op && !init;
  end

endmodule

// File: doc/serv_state_wide.md
Name: serv_state_wide

Overview:
- Parametrised control/sequencing block for the bit-serial core family, generalised to datapath width W ∈ {1,2,4,8}.
- Owns the 32-bit beat counter, the two-stage instruction sequencing, the ibus/dbus/RF request generation and the misalign-trap capture.
- Adds a counter stall input for wait-stated register files, and an explicit phase FSM in place of implicit flags.
- Sits between decode/ALU/bufreg and the RF interface and buses.

Parameters:
- W, 1, datapath bits per beat; legal values 1, 2, 4, 8; beats per pass N = 32/W.
- WITH_CSR, 1, enables trap generation and misalign capture; when 0, o_ctrl_trap = 0.
- ALIGN, 0, when 1 a misaligned jump target does not trap.
- MDU, 0, enables the MDU valid/ready path.
- RESET_STRATEGY, "MINI", "NONE" removes reset from all non-handshake flops.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_new_irq, i_alu_cmp, i_ctrl_misalign, i_mem_misalign  in  1 each  trap/branch inputs
- i_sh_done, i_sh_done_r  in  1 each  shifter status
- i_bne_or_bge, i_cond_branch, i_dbus_en, i_two_stage_op, i_branch_op, i_shift_op, i_sh_right, i_slt_or_branch, i_e_op, i_rd_op, i_mdu_op  in  1 each  decode
- i_mdu_ready  in  1  MDU result ready
- i_ibus_ack, i_dbus_ack  in  1 each  bus acks
- i_rf_ready  in  1  RF ready to stream
- i_cnt_stall  in  1  freeze beat counter this cycle
- o_cnt_en  out  1  datapath advance strobe
- o_cnt_pos  out  5  LSB bit index of current beat (multiple of W)
- o_cnt_bit  out  4  [k] = active beat contains bit k
- o_cnt7, o_cnt0to3, o_cnt12to31, o_cnt_done  out  1 each  position decodes
- o_mem_bytecnt  out  2  o_cnt_pos[4:3]
- o_init, o_bufreg_en, o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap, o_mdu_valid  out  1 each
- o_ibus_cyc, o_dbus_cyc, o_rf_rreq, o_rf_wreq, o_rf_rd_en  out  1 each

Behaviour:
- Reset state: phase IDLE, o_cnt_pos = 0, o_ctrl_jump = 0, trap capture = 0.
  - o_ibus_cyc is forced 0 while i_rst is high and is 1 the first cycle after release.
  - All other outputs are combinational from this state.
- Phase FSM:
  - IDLE → RUN1 on i_rf_ready.
  - RUN1 → WAIT at the done beat if o_init was high, else → IDLE.
  - WAIT → RUN2 on i_rf_ready.
  - RUN2 → IDLE at the done beat.
  - i_rf_ready while running is ignored.
- Counter:
  - o_cnt_en = (RUN1|RUN2) & !i_cnt_stall.
  - o_cnt_pos += W on each o_cnt_en cycle and wraps to 0 after the done beat.
  - o_cnt_done = o_cnt_en & (o_cnt_pos == 32-W).
  - A stall on the done beat holds the phase and position.
- Decodes, all gated by o_cnt_en:
  - o_cnt_bit[k] = (o_cnt_pos ≤ k < o_cnt_pos+W). For W ≥ 4, all four bits are high on beat 0.
  - o_cnt7 = beat contains bit 7.
  - o_cnt0to3 = o_cnt_pos < 4.
  - o_cnt12to31 = o_cnt_pos ≥ 12, or the beat contains bit 12.
- Stage control:
  - o_init = i_two_stage_op & !i_new_irq & (phase ≠ RUN2, WAIT).
  - take_branch = i_branch_op & (!i_cond_branch | (i_alu_cmp ^ i_bne_or_bge)).
  - o_ctrl_jump and the trap capture are registered at o_cnt_done of RUN1 only.
  - trap_pending = (take_branch & i_ctrl_misalign & !ALIGN) | (i_dbus_en & i_mem_misalign).
- Request generation:
  - o_ctrl_pc_en = o_cnt_en & !o_init.
  - o_ibus_cyc is set at o_cnt_done with o_ctrl_pc_en, and cleared on i_ibus_ack.
  - o_dbus_cyc = WAIT & i_dbus_en & !i_mem_misalign.
  - o_mdu_valid = MDU & WAIT & i_mdu_op.
  - o_rf_wreq = WAIT & !trap & (shift_ok | i_dbus_ack | (MDU & i_mdu_ready) | i_slt_or_branch), where shift_ok = i_shift_op & (i_sh_done | !i_sh_right).
  - o_rf_rreq = i_ibus_ack | (first WAIT cycle & trap).
  - o_rf_rd_en = i_rd_op & !o_init.
- o_bufreg_en = (o_cnt_en & (o_init | ((o_ctrl_trap | i_branch_op) & i_two_stage_op))) | (WAIT & i_shift_op & !first WAIT cycle & (i_sh_right | i_sh_done_r)).
- o_ctrl_trap = WITH_CSR & (i_e_op | i_new_irq | trap).
- Simultaneous i_ibus_ack and o_cnt_done: the ack wins and o_ibus_cyc is cleared.
- Reset mid-RUN: the next cycle is IDLE with position 0. No done pulse is emitted.

Test Plan:
- W=1, single-stage ADD: i_rf_ready pulse → o_cnt_en high 32 cycles, o_cnt_done on the 32nd, o_ibus_cyc rises next cycle, o_cnt_bit[3] only on beat 3.
- W=4, same op → 8 beats, o_cnt_pos 0,4,…,28, o_cnt_bit = 4'b1111 on beat 0, o_cnt7 on beat 1, o_mem_bytecnt steps 0,0,1,1,2,2,3,3.
- W=2, stall 3 cycles at pos 10 → pos held at 10, o_cnt_en low for 3 cycles, total pass length 19 cycles, done at pos 30.
- W=8, misaligned taken jump (i_ctrl_misalign=1, ALIGN=0) → after RUN1, o_ctrl_jump=1, trap captured, o_rf_rreq pulses in the first WAIT cycle, o_rf_wreq stays 0.
- Load W=4: RUN1 → WAIT, o_dbus_cyc=1 until i_dbus_ack → o_rf_wreq same cycle, i_rf_ready → RUN2 of 8 beats → IDLE, o_ibus_cyc=1.
- Assert i_rst at pos 16 of RUN1 → next cycle pos 0, IDLE, o_ctrl_jump 0; o_ibus_cyc 0 during reset and 1 the cycle after release.
